// File: rtl/jackpot_pkg.sv
// rtl/jackpot_pkg.sv - shared types and helpers for the jackpot reaction game
package jackpot_pkg;

  typedef enum logic [1:0] {
    REARM = 2'd0,
    RUN   = 2'd1,
    FLASH = 2'd2
  } state_t;

  localparam int MODE_ROTATE = 0;
  localparam int MODE_BOUNCE = 1;

  // Each level halves the walk step period.
  function automatic int period_for_level(input int div_base, input int level);
    return div_base >> level;
  endfunction

endpackage

// File: rtl/jackpot_arcade_if.sv
// rtl/jackpot_arcade_if.sv - board-facing signal bundle (switches in, display/score out)
interface jackpot_arcade_if #(
  parameter int N_LEDS  = 4,
  parameter int LEVELS  = 4,
  parameter int SCORE_W = 8
);

  logic [N_LEDS-1:0]          SWITCHES;
  logic [N_LEDS-1:0]          LEDS;
  logic                       WON;
  logic [$clog2(LEVELS)-1:0]  LEVEL;
  logic [SCORE_W-1:0]         SCORE;

  // master is the board/player side, slave is the game core
  modport master (output SWITCHES, input LEDS, input WON, input LEVEL, input SCORE);
  modport slave  (input SWITCHES, output LEDS, output WON, output LEVEL, output SCORE);

endinterface

// File: rtl/jackpot_tick_div.sv
// rtl/jackpot_tick_div.sv - free-running divider emitting a one-cycle tick every i_period cycles
module jackpot_tick_div #(
  parameter int PER_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PER_W-1:0] i_period,
  input  logic             i_clear,
  output logic             o_tick
);

  logic [PER_W-1:0] r_count;
  logic             w_last;

  // >= keeps the counter bounded even if the period shrinks under it
  assign w_last = (r_count >= (i_period - PER_W'(1)));
  assign o_tick = w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + PER_W'(1);
    end
  end

endmodule

// File: rtl/jackpot_arcade.sv
// rtl/jackpot_arcade.sv - walking-LED reaction game: synchroniser, FSM, position, score and level
module jackpot_arcade
  import jackpot_pkg::*;
#(
  parameter int N_LEDS      = 4,
  parameter int DIV_BASE    = 25_000_000,
  parameter int LEVELS      = 4,
  parameter int MODE        = MODE_ROTATE,
  parameter int FLASH_DIV   = 12_500_000,
  parameter int FLASH_COUNT = 3,
  parameter int SCORE_W     = 8
) (
  input  logic           CLOCK,
  input  logic           BTN0,
  jackpot_arcade_if.slave board
);

  localparam int POS_W   = $clog2(N_LEDS);
  localparam int LVL_W   = $clog2(LEVELS);
  localparam int PER_MAX = (DIV_BASE > FLASH_DIV) ? DIV_BASE : FLASH_DIV;
  localparam int PER_W   = $clog2(PER_MAX + 1);
  localparam int HALF_W  = $clog2(2 * FLASH_COUNT);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0]  POS_PRE   = POS_W'(N_LEDS - 2);
  localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(LEVELS - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FLASH_COUNT - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [N_LEDS-1:0]   r_sw_meta;
  logic [N_LEDS-1:0]   r_sw_s;
  logic [POS_W-1:0]    r_pos;
  logic                r_dir_down;
  logic                r_flash_on;
  logic [HALF_W-1:0]   r_half_cnt;
  logic [SCORE_W-1:0]  r_score;
  logic [LVL_W-1:0]    r_level;

  logic [N_LEDS-1:0]   w_onehot;
  logic [N_LEDS-1:0]   w_leds;
  logic                w_match;
  logic                w_tick;
  logic                w_clear;
  logic [PER_W-1:0]    w_period;
  logic [POS_W-1:0]    w_pos_next;
  logic                w_dir_next;

  assign w_onehot = N_LEDS'(1) << r_pos;
  assign w_match  = (r_sw_s == w_onehot);
  assign w_clear  = (w_state_next != r_state);
  assign w_period = (r_state == FLASH) ? PER_W'(FLASH_DIV)
                                       : PER_W'(period_for_level(DIV_BASE, int'(r_level)));

  jackpot_tick_div #(
    .PER_W (PER_W)
  ) u_tick_div (
    .clk      (CLOCK),
    .rst      (BTN0),
    .i_period (w_period),
    .i_clear  (w_clear),
    .o_tick   (w_tick)
  );

  always_ff @(posedge CLOCK) begin
    if (BTN0) begin
      r_state <= REARM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_leds       = w_onehot;
    case (r_state)
      REARM: begin
        if (r_sw_s == '0) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (w_match) begin
          w_state_next = FLASH;
        end
      end
      FLASH: begin
        w_leds = r_flash_on ? '1 : '0;
        if (w_tick && (r_half_cnt == HALF_LAST)) begin
          w_state_next = REARM;
        end
      end
      default: begin
        w_state_next = REARM;
      end
    endcase
  end

  // Bounce flips direction on arrival at an end so no end LED is shown twice.
  always_comb begin
    w_pos_next = r_pos;
    w_dir_next = r_dir_down;
    if (MODE == MODE_BOUNCE) begin
      if (r_dir_down) begin
        w_pos_next = r_pos - POS_W'(1);
        w_dir_next = (r_pos != POS_W'(1));
      end else begin
        w_pos_next = r_pos + POS_W'(1);
        w_dir_next = (r_pos == POS_PRE);
      end
    end else begin
      w_pos_next = (r_pos == POS_LAST) ? '0 : (r_pos + POS_W'(1));
    end
  end

  always_ff @(posedge CLOCK) begin
    if (BTN0) begin
      r_sw_meta  <= '0;
      r_sw_s     <= '0;
      r_pos      <= '0;
      r_dir_down <= 1'b0;
      r_flash_on <= 1'b0;
      r_half_cnt <= '0;
      r_score    <= '0;
      r_level    <= '0;
    end else begin
      r_sw_meta <= board.SWITCHES;
      r_sw_s    <= r_sw_meta;
      case (r_state)
        RUN: begin
          // A match beats a same-cycle tick: the position freezes for the flash.
          if (w_match) begin
            r_flash_on <= 1'b1;
            r_half_cnt <= '0;
            if (r_score != '1) begin
              r_score <= r_score + SCORE_W'(1);
            end
            if (r_level != LVL_LAST) begin
              r_level <= r_level + LVL_W'(1);
            end
          end else if (w_tick) begin
            r_pos      <= w_pos_next;
            r_dir_down <= w_dir_next;
          end
        end
        FLASH: begin
          if (w_tick) begin
            r_flash_on <= ~r_flash_on;
            r_half_cnt <= r_half_cnt + HALF_W'(1);
            if (r_half_cnt == HALF_LAST) begin
              r_pos      <= '0;
              r_dir_down <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign board.LEDS  = w_leds;
  assign board.WON   = (r_state == FLASH);
  assign board.LEVEL = r_level;
  assign board.SCORE = r_score;

endmodule

// File: tb/tb_jackpot_arcade.sv
// tb/tb_jackpot_arcade.sv - self-checking bench for jackpot_arcade (rotate and bounce instances)
module tb_jackpot_arcade;

  localparam int FLASH_LEN = 16;

  logic       clk = 1'b0;
  logic       btn = 1'b1;
  logic [3:0] t_sw = 4'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  jackpot_arcade_if #(.N_LEDS(4), .LEVELS(3), .SCORE_W(4)) if_rot ();
  jackpot_arcade_if #(.N_LEDS(4), .LEVELS(3), .SCORE_W(4)) if_bnc ();

  assign if_rot.SWITCHES = t_sw;
  assign if_bnc.SWITCHES = t_sw;

  jackpot_arcade #(
    .N_LEDS(4), .DIV_BASE(8), .LEVELS(3), .MODE(0),
    .FLASH_DIV(4), .FLASH_COUNT(2), .SCORE_W(4)
  ) dut_rot (
    .CLOCK (clk),
    .BTN0  (btn),
    .board (if_rot)
  );

  jackpot_arcade #(
    .N_LEDS(4), .DIV_BASE(8), .LEVELS(3), .MODE(1),
    .FLASH_DIV(4), .FLASH_COUNT(2), .SCORE_W(4)
  ) dut_bnc (
    .CLOCK (clk),
    .BTN0  (btn),
    .board (if_bnc)
  );

  // Reference model: time elapsed in the current game phase, from which the display is derived.
  int         m_state [2];
  int         m_el    [2];
  int         m_score [2];
  int         m_level [2];
  logic [3:0] m_meta  [2];
  logic [3:0] m_sync  [2];
  bit         m_live = 1'b0;

  function automatic logic [3:0] model_leds(input int i);
    int per;
    int k;
    int p;
    if (m_state[i] == 2) return (((m_el[i] / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
    if (m_state[i] == 0) return 4'b0001;
    per = 8 >> m_level[i];
    k   = m_el[i] / per;
    if (i == 0) begin
      p = k % 4;
    end else begin
      p = k % 6;
      if (p >= 4) p = 6 - p;
    end
    return 4'b0001 << p;
  endfunction

  task automatic model_edge(input int i);
    if (btn) begin
      m_state[i] = 0; m_el[i] = 0; m_score[i] = 0; m_level[i] = 0;
      m_meta[i] = 4'b0; m_sync[i] = 4'b0;
      return;
    end
    case (m_state[i])
      0: if (m_sync[i] == 4'b0) begin m_state[i] = 1; m_el[i] = 0; end
      1: begin
        if (m_sync[i] == model_leds(i)) begin
          m_state[i] = 2; m_el[i] = 0;
          if (m_score[i] < 15) m_score[i]++;
          if (m_level[i] < 2) m_level[i]++;
        end else begin
          m_el[i]++;
        end
      end
      default: begin
        m_el[i]++;
        if (m_el[i] == FLASH_LEN) begin m_state[i] = 0; m_el[i] = 0; end
      end
    endcase
    m_sync[i] = m_meta[i];
    m_meta[i] = t_sw;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    check("rot_leds",  32'(if_rot.LEDS),  32'(model_leds(0)));
    check("rot_won",   32'(if_rot.WON),   32'(m_state[0] == 2));
    check("rot_score", 32'(if_rot.SCORE), 32'(m_score[0]));
    check("rot_level", 32'(if_rot.LEVEL), 32'(m_level[0]));
    check("bnc_leds",  32'(if_bnc.LEDS),  32'(model_leds(1)));
    check("bnc_won",   32'(if_bnc.WON),   32'(m_state[1] == 2));
    check("bnc_score", 32'(if_bnc.SCORE), 32'(m_score[1]));
    check("bnc_level", 32'(if_bnc.LEVEL), 32'(m_level[1]));
  endtask

  task automatic step(input logic [3:0] sw, input logic b);
    @(negedge clk);
    t_sw = sw;
    btn  = b;
    @(posedge clk);
    if (b) m_live = 1'b1;
    for (int i = 0; i < 2; i++) model_edge(i);
    #1;
    if (m_live) compare_all();
  endtask

  task automatic win_once();
    int guard;
    guard = 0;
    while (m_state[0] != 1 && guard < 200) begin step(4'b0000, 1'b0); guard++; end
    while (m_state[0] != 2 && guard < 400) begin step(4'b0100, 1'b0); guard++; end
    while (m_state[0] == 2 && guard < 600) begin step(4'b0100, 1'b0); guard++; end
    check("win_budget", 32'(guard < 400 + FLASH_LEN + 10), 32'd1);
  endtask

  typedef struct {
    int         n;
    logic [3:0] sw;
    logic [3:0] leds;
    logic       won;
    int         score;
    int         level;
  } vec_t;

  vec_t tbl [13];

  logic [3:0] bnc_seq [8];

  initial begin
    int guard;
    int won_cnt;
    int moves;
    logic [3:0] prev;
    logic [3:0] pat [2];

    tbl[0]  = '{1, 4'b0000, 4'b0001, 1'b0, 0, 0};
    tbl[1]  = '{8, 4'b0000, 4'b0010, 1'b0, 0, 0};
    tbl[2]  = '{8, 4'b0000, 4'b0100, 1'b0, 0, 0};
    tbl[3]  = '{2, 4'b0100, 4'b0100, 1'b0, 0, 0};
    tbl[4]  = '{1, 4'b0100, 4'b1111, 1'b1, 1, 1};
    tbl[5]  = '{4, 4'b0100, 4'b0000, 1'b1, 1, 1};
    tbl[6]  = '{4, 4'b0100, 4'b1111, 1'b1, 1, 1};
    tbl[7]  = '{4, 4'b0100, 4'b0000, 1'b1, 1, 1};
    tbl[8]  = '{4, 4'b0100, 4'b0001, 1'b0, 1, 1};
    tbl[9]  = '{4, 4'b0100, 4'b0001, 1'b0, 1, 1};
    tbl[10] = '{3, 4'b0000, 4'b0001, 1'b0, 1, 1};
    tbl[11] = '{4, 4'b0000, 4'b0010, 1'b0, 1, 1};
    tbl[12] = '{4, 4'b0000, 4'b0100, 1'b0, 1, 1};

    bnc_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    // Reset state and the basic walk / win / rearm timeline
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("reset_leds",  32'(if_rot.LEDS),  32'h1);
    check("reset_won",   32'(if_rot.WON),   32'h0);
    check("reset_score", 32'(if_rot.SCORE), 32'h0);
    check("reset_level", 32'(if_rot.LEVEL), 32'h0);
    for (int v = 0; v < 13; v++) begin
      repeat (tbl[v].n) step(tbl[v].sw, 1'b0);
      check($sformatf("tbl%0d_leds", v),  32'(if_rot.LEDS),  32'(tbl[v].leds));
      check($sformatf("tbl%0d_won", v),   32'(if_rot.WON),   32'(tbl[v].won));
      check($sformatf("tbl%0d_score", v), 32'(if_rot.SCORE), 32'(tbl[v].score));
      check($sformatf("tbl%0d_level", v), 32'(if_rot.LEVEL), 32'(tbl[v].level));
    end

    // Bounce walk
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b0);
    check("bnc_seq0", 32'(if_bnc.LEDS), 32'(bnc_seq[0]));
    for (int j = 1; j < 8; j++) begin
      repeat (8) step(4'b0000, 1'b0);
      check($sformatf("bnc_seq%0d", j), 32'(if_bnc.LEDS), 32'(bnc_seq[j]));
    end

    // Level saturation, fastest step period, score saturation
    step(4'b0000, 1'b1);
    for (int w = 0; w < 3; w++) win_once();
    check("level_sat", 32'(if_rot.LEVEL), 32'd2);
    guard = 0;
    while (m_state[0] != 1 && guard < 50) begin step(4'b0000, 1'b0); guard++; end
    check("fast_run_entry", 32'(if_rot.LEDS), 32'h1);
    repeat (2) step(4'b0000, 1'b0);
    check("fast_step1", 32'(if_rot.LEDS), 32'h2);
    repeat (2) step(4'b0000, 1'b0);
    check("fast_step2", 32'(if_rot.LEDS), 32'h4);
    for (int w = 3; w < 17; w++) win_once();
    check("score_sat", 32'(if_rot.SCORE), 32'd15);
    check("level_hold", 32'(if_rot.LEVEL), 32'd2);

    // Reset in the middle of a flash
    guard = 0;
    while (m_state[0] != 1 && guard < 50) begin step(4'b0000, 1'b0); guard++; end
    while (m_state[0] != 2 && guard < 100) begin step(4'b0100, 1'b0); guard++; end
    repeat (3) step(4'b0100, 1'b0);
    check("midflash_won", 32'(if_rot.WON), 32'd1);
    step(4'b0100, 1'b1);
    check("midflash_rst_leds",  32'(if_rot.LEDS),  32'h1);
    check("midflash_rst_won",   32'(if_rot.WON),   32'h0);
    check("midflash_rst_score", 32'(if_rot.SCORE), 32'h0);
    check("midflash_rst_level", 32'(if_rot.LEVEL), 32'h0);

    // Non-one-hot switch patterns never win and do not stop the walk
    pat = '{4'b0110, 4'b1111};
    for (int q = 0; q < 2; q++) begin
      step(4'b0000, 1'b1);
      repeat (2) step(4'b0000, 1'b0);
      won_cnt = 0;
      moves   = 0;
      prev    = if_rot.LEDS;
      for (int c = 0; c < 64; c++) begin
        step(pat[q], 1'b0);
        if (if_rot.WON || if_bnc.WON) won_cnt++;
        if (if_rot.LEDS != prev) moves++;
        prev = if_rot.LEDS;
      end
      check($sformatf("nowin_%0h", pat[q]), 32'(won_cnt), 32'd0);
      check($sformatf("walk_%0h", pat[q]), 32'(moves >= 7), 32'd1);
    end

    // Randomised play against the reference model
    step(4'b0000, 1'b1);
    for (int c = 0; c < 1500;) begin
      int r;
      int hold;
      logic [3:0] val;
      r    = $urandom_range(0, 99);
      hold = $urandom_range(1, 8);
      if (r < 40)      val = 4'b0001 << $urandom_range(0, 3);
      else if (r < 65) val = 4'b0000;
      else             val = 4'($urandom);
      if (r == 99) begin
        step(val, 1'b1);
        c++;
      end else begin
        repeat (hold) step(val, 1'b0);
        c += hold;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
